// File: rtl/output_arbiter_if.sv
// Bus bundle between the four requesting input ports, the output link and
// one output_arbiter instance. The arbiter uses the slave side.
interface output_arbiter_if #(
  parameter int FLIT_W = 34
);
  logic [4*FLIT_W-1:0] req_flit;
  logic [3:0]          req_valid;
  logic [3:0]          block;
  logic [FLIT_W-1:0]   out_flit;
  logic                out_valid;
  logic                credit_in;
  logic                err;

  modport master (
    output req_flit, req_valid, credit_in,
    input  block, out_flit, out_valid, err
  );

  modport slave (
    input  req_flit, req_valid, credit_in,
    output block, out_flit, out_valid, err
  );
endinterface

// File: rtl/output_arbiter.sv
// Output stage of one mesh-router port: round-robin arbitration among four
// requesters with wormhole locking, a registered output link under
// credit-based flow control, and per-requester block signals.
module output_arbiter #(
  parameter int FLIT_W    = 34,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input  logic           clk,
  input  logic           rst,
  output_arbiter_if.slave bus
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [1:0] TYPE_BODY   = 2'b00;
  localparam logic [1:0] TYPE_HEAD   = 2'b01;
  localparam logic [1:0] TYPE_TAIL   = 2'b10;
  localparam logic [1:0] TYPE_SINGLE = 2'b11;

  localparam logic [CNT_W-1:0] CREDIT_FULL = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] CREDIT_ONE  = CNT_W'(1);

  logic [0:0]        state_q,     state_d;
  logic [1:0]        owner_q,     owner_d;
  logic [1:0]        rr_ptr_q,    rr_ptr_d;
  logic [CNT_W-1:0]  credits_q,   credits_d;
  logic [FLIT_W-1:0] out_flit_q,  out_flit_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q,       err_d;

  logic [3:0]        cand_s;
  logic [7:0]        dbl_s;
  logic [3:0]        rot_s;
  logic [1:0]        off_s;
  logic              grant_s;
  logic [1:0]        grant_idx_s;
  logic [3:0]        accept_s;
  logic [FLIT_W-1:0] acc_flit_s;
  logic [1:0]        acc_type_s;

  // Candidates for a new packet: valid requesters presenting a head or single
  // (both types have the low type bit set).
  always_comb begin
    cand_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cand_s[i] = bus.req_valid[i] & bus.req_flit[i*FLIT_W + FLIT_W - 2];
    end
  end

  // Rotate candidates so rr_ptr sits at bit 0, then pick the lowest set bit.
  always_comb begin
    dbl_s = {cand_s, cand_s} >> rr_ptr_q;
    rot_s = dbl_s[3:0];
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
  end

  // Grant decision: locked ports serve only the owner; no credit, no grant.
  always_comb begin
    grant_s     = 1'b0;
    grant_idx_s = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        grant_s     = (|cand_s) && (credits_q != {CNT_W{1'b0}});
        grant_idx_s = rr_ptr_q + off_s;
      end
      ST_LOCKED: begin
        grant_s     = bus.req_valid[owner_q] && (credits_q != {CNT_W{1'b0}});
        grant_idx_s = owner_q;
      end
      default: begin
        grant_s     = 1'b0;
        grant_idx_s = rr_ptr_q;
      end
    endcase
    if (grant_s) begin
      accept_s = 4'b0001 << grant_idx_s;
    end else begin
      accept_s = 4'b0000;
    end
    acc_flit_s = bus.req_flit[grant_idx_s*FLIT_W +: FLIT_W];
    acc_type_s = acc_flit_s[FLIT_W-1 -: 2];
  end

  // Next-state: FSM, round-robin pointer, output register, credits, error.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    credits_d   = credits_q;
    out_flit_d  = out_flit_q;
    out_valid_d = 1'b0;
    err_d       = err_q;

    if (grant_s) begin
      out_flit_d  = acc_flit_s;
      out_valid_d = 1'b1;
      if (state_q == ST_IDLE) begin
        rr_ptr_d = grant_idx_s + 2'd1;
        if (acc_type_s == TYPE_HEAD) begin
          state_d = ST_LOCKED;
          owner_d = grant_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        case (acc_type_s)
          TYPE_TAIL:   state_d = ST_IDLE;
          TYPE_HEAD:   err_d   = 1'b1;
          TYPE_SINGLE: err_d   = 1'b1;
          TYPE_BODY:   state_d = ST_LOCKED;
          default:     state_d = ST_LOCKED;
        endcase
      end
    end else begin
      out_valid_d = 1'b0;
    end

    // A simultaneous accept and returned credit cancel out.
    if (grant_s && !bus.credit_in) begin
      credits_d = credits_q - CREDIT_ONE;
    end else if (!grant_s && bus.credit_in) begin
      if (credits_q == CREDIT_FULL) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + CREDIT_ONE;
      end
    end else begin
      credits_d = credits_q;
    end
  end

  // State registers; reset abandons any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 2'd0;
      rr_ptr_q    <= 2'd0;
      credits_q   <= CREDIT_FULL;
      out_flit_q  <= {FLIT_W{1'b0}};
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      credits_q   <= credits_d;
      out_flit_q  <= out_flit_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.block     = bus.req_valid & ~accept_s;
  assign bus.out_flit  = out_flit_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_output_arbiter.sv
// Self-checking bench for output_arbiter: directed scenarios plus a random
// run compared against a packet-level reference model.
module tb_output_arbiter;
  localparam int FW    = 34;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_arbiter_if #(.FLIT_W(FW)) bus();

  output_arbiter #(.FLIT_W(FW), .BUF_DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [FW-1:0] slot_f [4];
  logic [3:0]    v;
  logic          cin;

  // Reference model state
  int            m_owner;    // -1 when no packet holds the port
  int            m_rr;
  int            m_credits;
  logic          m_err;
  logic [FW-1:0] m_out_flit;
  logic          m_out_valid;
  int            m_acc;
  logic [3:0]    exp_blk;
  logic [3:0]    got_blk;

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] p);
    return {t, p};
  endfunction

  function automatic logic [1:0] ftype(input logic [FW-1:0] f);
    return f[FW-1:FW-2];
  endfunction

  function automatic int m_pick();
    int i;
    if (m_credits == 0) return -1;
    if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < 4; k++) begin
      i = (m_rr + k) % 4;
      if (v[i] && (ftype(slot_f[i]) == 2'b01 || ftype(slot_f[i]) == 2'b11)) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_credits = DEPTH; m_err = 1'b0;
    m_out_flit = '0; m_out_valid = 1'b0;
  endtask

  task automatic model_commit(input int acc, input logic ci);
    logic [1:0] t;
    if (acc >= 0) begin
      t = ftype(slot_f[acc]);
      m_out_flit = slot_f[acc];
      m_out_valid = 1'b1;
      if (m_owner < 0) begin
        m_rr = (acc + 1) % 4;
        if (t == 2'b01) m_owner = acc;
      end else if (t == 2'b10) begin
        m_owner = -1;
      end else if (t[0]) begin
        m_err = 1'b1;
      end
    end else begin
      m_out_valid = 1'b0;
    end
    if (acc >= 0 && !ci) m_credits--;
    else if (acc < 0 && ci) begin
      if (m_credits == DEPTH) m_err = 1'b1;
      else m_credits++;
    end
  endtask

  task automatic drive();
    bus.req_valid = v;
    bus.credit_in = cin;
    for (int i = 0; i < 4; i++) bus.req_flit[i*FW +: FW] = slot_f[i];
  endtask

  // One clock: drive at negedge, sample block, step model at posedge, settle.
  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    m_acc = m_pick();
    exp_blk = v & ~((m_acc >= 0) ? 4'(1 << m_acc) : 4'b0000);
    got_blk = bus.block;
    @(posedge clk);
    model_commit(m_acc, cin);
    #1;
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    v = 4'b0000; cin = 1'b0;
    for (int i = 0; i < 4; i++) slot_f[i] = '0;
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    hard_reset();
    #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset.out_valid got %b exp 0", bus.out_valid); end
    n_vec++; if (bus.out_flit !== '0) begin n_err++; $display("FAIL reset.out_flit got %h exp 0", bus.out_flit); end
    n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL reset.err got %b exp 0", bus.err); end
    n_vec++; if (bus.block !== 4'b0000) begin n_err++; $display("FAIL reset.block got %b exp 0000", bus.block); end
  endtask

  task automatic test_single();
    hard_reset();
    slot_f[2] = mk(2'b11, 32'h5); v = 4'b0100;
    cycle();
    n_vec++; if (got_blk !== 4'b0000) begin n_err++; $display("FAIL single.block got %b exp 0000", got_blk); end
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single.out_valid got %b exp 1", bus.out_valid); end
    n_vec++; if (bus.out_flit !== mk(2'b11, 32'h5)) begin n_err++; $display("FAIL single.out_flit got %h exp %h", bus.out_flit, mk(2'b11, 32'h5)); end
    // rr_ptr is now 3: slot 3 must beat slot 0.
    slot_f[2] = '0; slot_f[0] = mk(2'b11, 32'hA); slot_f[3] = mk(2'b11, 32'hB); v = 4'b1001;
    cycle();
    n_vec++; if (got_blk !== 4'b0001) begin n_err++; $display("FAIL single.rr_block got %b exp 0001", got_blk); end
    n_vec++; if (bus.out_flit !== mk(2'b11, 32'hB)) begin n_err++; $display("FAIL single.rr_flit got %h exp %h", bus.out_flit, mk(2'b11, 32'hB)); end
  endtask

  task automatic test_round_robin();
    int w;
    hard_reset();
    for (int i = 0; i < 4; i++) slot_f[i] = mk(2'b11, 32'(i));
    v = 4'b1111; cin = 1'b1;
    for (int k = 0; k < 5; k++) begin
      w = k % 4;
      cycle();
      n_vec++; if (got_blk !== (4'b1111 & ~4'(1 << w))) begin n_err++; $display("FAIL rr.block[%0d] got %b exp %b", k, got_blk, 4'b1111 & ~4'(1 << w)); end
      n_vec++; if (bus.out_flit !== mk(2'b11, 32'(w))) begin n_err++; $display("FAIL rr.flit[%0d] got %h exp %h", k, bus.out_flit, mk(2'b11, 32'(w))); end
    end
    n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL rr.err got %b exp 0", bus.err); end
    // Credits must still be full: one spare credit now overflows.
    v = 4'b0000;
    cycle();
    n_vec++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL rr.credits_full got err %b exp 1", bus.err); end
    cin = 1'b0;
  endtask

  task automatic test_wormhole();
    logic [1:0] ty [3];
    ty[0] = 2'b01; ty[1] = 2'b00; ty[2] = 2'b10;
    hard_reset();
    slot_f[3] = mk(2'b01, 32'h33);
    for (int k = 0; k < 3; k++) begin
      slot_f[1] = mk(ty[k], 32'(16 + k)); v = 4'b1010;
      cycle();
      n_vec++; if (got_blk !== 4'b1000) begin n_err++; $display("FAIL worm.block[%0d] got %b exp 1000", k, got_blk); end
      n_vec++; if (bus.out_flit !== mk(ty[k], 32'(16 + k))) begin n_err++; $display("FAIL worm.flit[%0d] got %h exp %h", k, bus.out_flit, mk(ty[k], 32'(16 + k))); end
    end
    v = 4'b1000;
    cycle();
    n_vec++; if (got_blk !== 4'b0000) begin n_err++; $display("FAIL worm.next_block got %b exp 0000", got_blk); end
    n_vec++; if (bus.out_flit !== mk(2'b01, 32'h33)) begin n_err++; $display("FAIL worm.next_flit got %h exp %h", bus.out_flit, mk(2'b01, 32'h33)); end
  endtask

  task automatic test_credit_exhaustion();
    logic [7:0] blk_tab;
    logic [7:0] ov_tab;
    logic [7:0] cin_tab;
    int acc_cnt;
    blk_tab = 8'b1011_0000; ov_tab = 8'b0100_1111; cin_tab = 8'b0010_0000;
    hard_reset();
    acc_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      slot_f[0] = mk((acc_cnt == 0) ? 2'b01 : 2'b00, 32'(acc_cnt)); v = 4'b0001; cin = cin_tab[k];
      cycle();
      n_vec++; if (got_blk[0] !== blk_tab[k]) begin n_err++; $display("FAIL credit.block[%0d] got %b exp %b", k, got_blk[0], blk_tab[k]); end
      n_vec++; if (bus.out_valid !== ov_tab[k]) begin n_err++; $display("FAIL credit.out_valid[%0d] got %b exp %b", k, bus.out_valid, ov_tab[k]); end
      if (!blk_tab[k]) begin
        n_vec++; if (bus.out_flit[31:0] !== 32'(acc_cnt)) begin n_err++; $display("FAIL credit.payload[%0d] got %0d exp %0d", k, bus.out_flit[31:0], acc_cnt); end
        acc_cnt++;
      end
    end
    cin = 1'b0;
  endtask

  task automatic test_errors();
    hard_reset();
    cin = 1'b1;
    cycle();
    n_vec++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL err.overflow got %b exp 1", bus.err); end
    cin = 1'b0; slot_f[0] = mk(2'b11, 32'h7); v = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_vec++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL err.sticky[%0d] got %b exp 1", k, bus.err); end
    end
    hard_reset();
    #1;
    n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL err.cleared got %b exp 0", bus.err); end
    slot_f[0] = mk(2'b01, 32'h1); v = 4'b0001;
    cycle();
    n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL err.first_head got %b exp 0", bus.err); end
    slot_f[0] = mk(2'b01, 32'h2);
    cycle();
    n_vec++; if (got_blk !== 4'b0000) begin n_err++; $display("FAIL err.head_accept got %b exp 0000", got_blk); end
    n_vec++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL err.mid_head got %b exp 1", bus.err); end
    slot_f[0] = mk(2'b10, 32'h3);
    cycle();
    n_vec++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL err.after_tail got %b exp 1", bus.err); end
  endtask

  task automatic test_reset_mid_packet();
    hard_reset();
    slot_f[2] = mk(2'b01, 32'h20); v = 4'b0100;
    cycle();
    slot_f[2] = mk(2'b00, 32'h21);
    cycle();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst.out_valid got %b exp 0", bus.out_valid); end
    n_vec++; if (bus.out_flit !== '0) begin n_err++; $display("FAIL midrst.out_flit got %h exp 0", bus.out_flit); end
    @(negedge clk);
    rst = 1'b0;
    slot_f[2] = mk(2'b00, 32'h22); slot_f[1] = mk(2'b11, 32'h9); v = 4'b0110;
    cycle();
    n_vec++; if (got_blk !== 4'b0100) begin n_err++; $display("FAIL midrst.block got %b exp 0100", got_blk); end
    n_vec++; if (bus.out_flit !== mk(2'b11, 32'h9)) begin n_err++; $display("FAIL midrst.flit got %h exp %h", bus.out_flit, mk(2'b11, 32'h9)); end
    v = 4'b0000; cin = 1'b1;
    cycle();
    n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL midrst.refill got err %b exp 0", bus.err); end
    cycle();
    n_vec++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL midrst.full got err %b exp 1", bus.err); end
    cin = 1'b0;
  endtask

  task automatic test_random();
    hard_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) slot_f[i] = mk(2'($urandom_range(0, 3)), $urandom);
      v   = 4'($urandom_range(0, 15));
      cin = ($urandom_range(0, 2) == 0);
      cycle();
      n_vec++; if (got_blk !== exp_blk) begin n_err++; $display("FAIL rand.block[%0d] got %b exp %b", n, got_blk, exp_blk); end
      n_vec++; if (bus.out_valid !== m_out_valid) begin n_err++; $display("FAIL rand.out_valid[%0d] got %b exp %b", n, bus.out_valid, m_out_valid); end
      n_vec++; if (bus.out_flit !== m_out_flit) begin n_err++; $display("FAIL rand.out_flit[%0d] got %h exp %h", n, bus.out_flit, m_out_flit); end
      n_vec++; if (bus.err !== m_err) begin n_err++; $display("FAIL rand.err[%0d] got %b exp %b", n, bus.err, m_err); end
    end
    cin = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_wormhole();
    test_credit_exhaustion();
    test_errors();
    test_reset_mid_packet();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/output_arbiter.md
Name: output_arbiter

Overview:
- Output stage of the 5-port mesh router; one instance per output port.
- Consumes the modified flits that the other four input ports route toward this port.
- Arbitrates among them round-robin with wormhole locking, so a packet holds the port from head to tail.
- Drives the registered output link under credit-based flow control and returns per-requester block signals that the input ports OR into their stall lines.

Parameters:
- FLIT_W, 34, modified flit width; bits [FLIT_W-1:FLIT_W-2] are the flit type, the rest is payload.
- BUF_DEPTH, 4, flit slots in the downstream buffer; this is the initial credit count.
- CNT_W, 3, credit counter width; must satisfy 2^CNT_W > BUF_DEPTH.

Ports:
- clk  input  1  router clock
- rst  input  1  asynchronous, active-high reset
- req_flit  input  4*FLIT_W  requester flits, slot i = bits [i*FLIT_W +: FLIT_W]
- req_valid  input  4  requester i presents a flit
- block  output  4  requester i must hold its flit this cycle
- out_flit  output  FLIT_W  registered output flit
- out_valid  output  1  out_flit valid this cycle
- credit_in  input  1  one-cycle pulse: downstream freed one slot
- err  output  1  sticky protocol-error flag

Behaviour:
- Flit types: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single-flit packet (head and tail).
- Reset (asynchronous, immediate):
  - state=IDLE, owner=0, rr_ptr=0, credits=BUF_DEPTH.
  - out_flit=0, out_valid=0, err=0.
  - Any packet in flight is abandoned; no partial tail is emitted.
- FSM IDLE:
  - Candidates are requesters with req_valid=1 and type head or single.
  - If credits>0, the winner is the first candidate searching rr_ptr, rr_ptr+1, ... (mod 4).
  - On a grant, rr_ptr <= winner+1 (mod 4).
  - Type head: go to LOCKED and set owner=winner.
  - Type single: stay in IDLE.
- FSM LOCKED:
  - Only the owner can be accepted; accept when req_valid[owner]=1 and credits>0.
  - An accepted tail returns the FSM to IDLE; rr_ptr is unchanged.
  - An accepted head or single from the owner while LOCKED: accept it, set err=1, remain LOCKED.
- Accept:
  - At most one requester per cycle.
  - Next edge: out_flit <= accepted flit, out_valid <= 1. Latency from acceptance is exactly 1 cycle.
  - With no accept, out_valid <= 0 and out_flit holds its value.
- block[i] is combinational: block[i] = req_valid[i] & ~accept[i]. A requester with req_valid=0 is never blocked.
- Credits:
  - Accept only: decrement.
  - credit_in only: increment.
  - Both in the same cycle: unchanged.
  - credits==0: nothing is accepted and all valid requesters are blocked.
  - credit_in while credits==BUF_DEPTH with no accept: saturate at BUF_DEPTH and set err=1.
- Body or tail presented in IDLE: never accepted, stays blocked, err is not set (the flit belongs to a packet waiting for its head elsewhere).
- Owner with req_valid=0 while LOCKED: bubble; the port stays locked and other requesters stay blocked.
- err clears only on rst.

Test Plan:
- Single-flit packet: after reset, slot 2 valid with type 11, payload 0x5 -> next cycle out_valid=1, out_flit={2'b11,0x5}; block=0; credits 4->3; rr_ptr=3; FSM remains IDLE.
- Round-robin fairness: all four slots hold single-flit packets continuously, credit_in pulsed every cycle -> grants in order 0,1,2,3,0; each block[i] low only in its grant cycle; credits remain 4.
- Wormhole lock:
  - Slot 1 sends head, body, tail while slot 3 presents a head throughout -> output is slot 1's three flits back to back, block[3]=1 for three cycles.
  - Slot 3's head is granted on the cycle after slot 1's tail is accepted.
- Credit exhaustion: no credit_in, slot 0 streams head plus six bodies -> four flits accepted, then block[0]=1 and out_valid=0; one credit_in pulse -> exactly one more flit is emitted one cycle after its accept.
- Errors:
  - Extra credit_in at credits=4 -> err=1 and credits stay 4.
  - A head from the owner mid-packet -> err=1.
  - err stays 1 until rst.
- Reset mid-packet: assert rst after head and body from slot 2 -> out_valid=0 immediately, credits=4; after release, a single-flit packet from slot 1 is granted.
